// File: rtl/pixel_plot_pkg.sv
// Shared types for the pixel plot receiver: FSM encoding, default framebuffer size,
// and the packed plot request held in the request FIFO.
package pixel_plot_pkg;

  localparam int unsigned DefFbWidth  = 160;
  localparam int unsigned DefFbHeight = 120;
  localparam int unsigned AddrWidth   = 15;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StDrain = 2'd1,
    StClear = 2'd2
  } state_e;

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
  } plot_entry_t;

endpackage

// File: rtl/plot_fifo.sv
// Show-ahead FIFO of plot requests; the head entry is visible on rdata while non-empty.
module plot_fifo
  import pixel_plot_pkg::*;
#(
  parameter int unsigned Depth = 4,
  localparam int unsigned PtrW = $clog2(Depth)
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic        push,
  input  logic        pop,
  input  plot_entry_t wdata,
  output plot_entry_t rdata,
  output logic        full,
  output logic        empty,
  output logic [PtrW:0] count
);

  plot_entry_t   mem [Depth];
  logic [PtrW:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW:0] rd_ptr_q, rd_ptr_d;
  logic          do_push, do_pop;

  // Pointers carry one wrap bit so full and empty are distinguishable.
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                   (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);
  assign count   = wr_ptr_q - rd_ptr_q;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr_q[PtrW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (do_push) mem[wr_ptr_q[PtrW-1:0]] <= wdata;
  end

endmodule

// File: rtl/pixel_plot_receiver.sv
// Buffers pixel plot requests and turns them into one framebuffer write per cycle.
// Define PIXEL_PLOT_CLEAR_EN to add the full-screen clear sweep and its ports.
module pixel_plot_receiver
  import pixel_plot_pkg::*;
#(
  parameter int unsigned FB_WIDTH   = DefFbWidth,
  parameter int unsigned FB_HEIGHT  = DefFbHeight,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic [7:0]  x,
  input  logic [6:0]  y,
  input  logic [2:0]  colour,
  input  logic        plot,
`ifdef PIXEL_PLOT_CLEAR_EN
  input  logic        clear,
  input  logic [2:0]  clear_colour,
`endif
  output logic        ready,
  output logic [14:0] fb_addr,
  output logic [2:0]  fb_data,
  output logic        fb_wren,
  output logic        busy,
  output logic [7:0]  drop_count
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [AddrWidth-1:0] LastAddr = AddrWidth'(FB_WIDTH * FB_HEIGHT - 1);

`ifndef PIXEL_PLOT_CLEAR_EN
  // Without the clear feature the request is tied off and StClear is unreachable.
  logic       clear;
  logic [2:0] clear_colour;
  assign clear        = 1'b0;
  assign clear_colour = 3'b000;
`endif

  state_e               state_q, state_d;
  logic                 clear_pending_q, clear_pending_d;
  logic [2:0]           clear_colour_q, clear_colour_d;
  logic [AddrWidth-1:0] clr_addr_q, clr_addr_d;

  logic                 fb_wren_q, fb_wren_d;
  logic [AddrWidth-1:0] fb_addr_q, fb_addr_d;
  logic [2:0]           fb_data_q, fb_data_d;
  logic [7:0]           drop_q, drop_d;

  plot_entry_t          in_entry, head;
  logic                 fifo_full, fifo_empty, push, pop;
  logic [PtrW:0]        count, count_next;
  logic                 in_range;
  logic [AddrWidth-1:0] head_addr;

  assign in_entry = '{x: x, y: y, colour: colour};
  assign ready    = !reset && !fifo_full && !clear_pending_q && (state_q != StClear);
  assign push     = plot && ready;
  // StDrain is held exactly while the FIFO has entries, so it doubles as the pop strobe.
  assign pop      = (state_q == StDrain);
  assign count_next = count + CntW'(push) - CntW'(pop);

  plot_fifo #(
    .Depth(FIFO_DEPTH)
  ) u_fifo (
    .CLOCK_50(CLOCK_50),
    .reset   (reset),
    .push    (push),
    .pop     (pop),
    .wdata   (in_entry),
    .rdata   (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (count)
  );

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q         <= StIdle;
      clear_pending_q <= 1'b0;
      clear_colour_q  <= 3'b000;
      clr_addr_q      <= '0;
      fb_wren_q       <= 1'b0;
      fb_addr_q       <= '0;
      fb_data_q       <= 3'b000;
      drop_q          <= 8'd0;
    end else begin
      state_q         <= state_d;
      clear_pending_q <= clear_pending_d;
      clear_colour_q  <= clear_colour_d;
      clr_addr_q      <= clr_addr_d;
      fb_wren_q       <= fb_wren_d;
      fb_addr_q       <= fb_addr_d;
      fb_data_q       <= fb_data_d;
      drop_q          <= drop_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    clear_pending_d = clear_pending_q;
    clear_colour_d  = clear_colour_q;
    clr_addr_d      = clr_addr_q;
    case (state_q)
      StClear: begin
        clr_addr_d = clr_addr_q + 1'b1;
        if (clr_addr_q == LastAddr) state_d = StIdle;
      end
      default: begin
        if (clear && !clear_pending_q) begin
          clear_pending_d = 1'b1;
          clear_colour_d  = clear_colour;
        end
        // A pending clear waits until the FIFO has fully drained.
        if (clear_pending_q && (count_next == '0)) begin
          state_d         = StClear;
          clear_pending_d = 1'b0;
          clr_addr_d      = '0;
        end else begin
          state_d = (count_next != '0) ? StDrain : StIdle;
        end
      end
    endcase
  end

  assign in_range  = (32'(head.x) < FB_WIDTH) && (32'(head.y) < FB_HEIGHT);
  assign head_addr = AddrWidth'(head.y) * AddrWidth'(FB_WIDTH) + AddrWidth'(head.x);

  always_comb begin
    fb_wren_d = 1'b0;
    fb_addr_d = fb_addr_q;
    fb_data_d = fb_data_q;
    drop_d    = drop_q;
    case (state_q)
      StDrain: begin
        if (in_range) begin
          fb_wren_d = 1'b1;
          fb_addr_d = head_addr;
          fb_data_d = head.colour;
        end else if (drop_q != 8'hFF) begin
          drop_d = drop_q + 8'd1;
        end
      end
      StClear: begin
        fb_wren_d = 1'b1;
        fb_addr_d = clr_addr_q;
        fb_data_d = clear_colour_q;
      end
      default: ;
    endcase
  end

  assign fb_wren    = fb_wren_q;
  assign fb_addr    = fb_addr_q;
  assign fb_data    = fb_data_q;
  assign drop_count = drop_q;
  assign busy       = !fifo_empty || fb_wren_q || clear_pending_q || (state_q == StClear);

endmodule
